// File: rtl/audio_pkg.sv
// Shared constants and types for the audio tone path.
package audio_pkg;

    localparam int unsigned PERIOD_WIDTH        = 24;
    localparam int unsigned VOLUME_WIDTH        = 4;
    localparam logic [VOLUME_WIDTH-1:0] VOLUME_MAX     = 4'd15;
    localparam int unsigned DEFAULT_HALF_PERIOD = 37878;
    localparam logic [VOLUME_WIDTH-1:0] VOLUME_DEFAULT = 4'd8;

    typedef logic [PERIOD_WIDTH-1:0] period_t;
    typedef logic [VOLUME_WIDTH-1:0] volume_t;

    // One-deep holding slot for a tone request waiting for its boundary.
    typedef struct packed {
        logic    valid;
        period_t period;
    } tone_slot_t;

    // What the divider does in a given cycle.
    typedef enum logic [1:0] {
        DivIdle,
        DivCount,
        DivEdge
    } div_step_t;

    // True on the last cycle of a running half-period.
    function automatic logic at_boundary(period_t count, period_t active);
        return (active != '0) && (count == active - period_t'(1));
    endfunction

endpackage

// File: rtl/volume_stepper.sv
// Saturating up/down volume counter driven by single-cycle pulses.
module volume_stepper
    import audio_pkg::*;
#(
    parameter logic [VOLUME_WIDTH-1:0] ResetValue = VOLUME_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    up_i,
    input  logic                    down_i,
    output logic [VOLUME_WIDTH-1:0] value_o
);

    volume_t value_q, value_d;

    // Step one unit toward the requested direction; simultaneous pulses cancel.
    always_comb begin
        value_d = value_q;
        if (up_i && !down_i && (value_q != VOLUME_MAX)) begin
            value_d = value_q + volume_t'(1);
        end else if (down_i && !up_i && (value_q != '0)) begin
            value_d = value_q - volume_t'(1);
        end
    end

    // Volume register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= ResetValue;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/square_wave_generator.sv
// Programmable square-wave tone source with glitch-free period updates and
// a saturating volume control for the AC97 controller.
module square_wave_generator #(
    parameter int unsigned DEFAULT_HALF_PERIOD = audio_pkg::DEFAULT_HALF_PERIOD,
    parameter logic [audio_pkg::VOLUME_WIDTH-1:0] VOLUME_DEFAULT = audio_pkg::VOLUME_DEFAULT
) (
    input  logic                              system_clock,
    input  logic                              system_reset_n,
    input  logic                              enable,
    input  logic [audio_pkg::PERIOD_WIDTH-1:0] tone_half_period,
    input  logic                              tone_valid,
    output logic                              tone_ready,
    input  logic                              volume_up,
    input  logic                              volume_down,
    output logic                              square_wave,
    output logic                              edge_strobe,
    output logic [audio_pkg::VOLUME_WIDTH-1:0] volume_control
);

    localparam audio_pkg::period_t ResetHalfPeriod =
        audio_pkg::period_t'(DEFAULT_HALF_PERIOD);

    audio_pkg::period_t    count_q, count_d;
    audio_pkg::period_t    active_q, active_d;
    audio_pkg::tone_slot_t slot_q, slot_d;
    logic                  ready_q, ready_d;
    logic                  wave_q, wave_d;
    logic                  strobe_q, strobe_d;

    audio_pkg::div_step_t  div_step;
    logic                  running;
    logic                  transfer;
    logic                  commit;

    // Classify the cycle: idle (silent or disabled), counting, or at a boundary.
    // A pending request commits at a boundary, or at once when there is none.
    always_comb begin
        running  = enable && (active_q != '0);
        if (!running) begin
            div_step = audio_pkg::DivIdle;
        end else if (audio_pkg::at_boundary(count_q, active_q)) begin
            div_step = audio_pkg::DivEdge;
        end else begin
            div_step = audio_pkg::DivCount;
        end
        transfer = tone_valid && ready_q;
        commit   = slot_q.valid && (div_step != audio_pkg::DivCount);
    end

    // Divider: count within the half-period, toggle at its end, park low when idle.
    always_comb begin
        count_d  = count_q;
        wave_d   = wave_q;
        strobe_d = 1'b0;
        unique case (div_step)
            audio_pkg::DivIdle: begin
                count_d = '0;
                if (wave_q) begin
                    wave_d   = 1'b0;
                    strobe_d = 1'b1;
                end
            end
            audio_pkg::DivEdge: begin
                count_d  = '0;
                wave_d   = !wave_q;
                strobe_d = 1'b1;
            end
            audio_pkg::DivCount: begin
                count_d = count_q + audio_pkg::period_t'(1);
            end
            default: begin
                count_d = '0;
            end
        endcase
    end

    // Pending slot and handshake. Commit and transfer never coincide because a
    // transfer needs an empty slot and a commit needs a full one.
    always_comb begin
        active_d = active_q;
        slot_d   = slot_q;
        if (commit) begin
            active_d     = slot_q.period;
            slot_d.valid = 1'b0;
        end
        if (transfer) begin
            slot_d.valid  = 1'b1;
            slot_d.period = tone_half_period;
        end
        ready_d = !slot_d.valid;
    end

    // Divider, slot and output registers.
    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            count_q  <= '0;
            active_q <= ResetHalfPeriod;
            slot_q   <= '0;
            ready_q  <= 1'b1;
            wave_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
            slot_q   <= slot_d;
            ready_q  <= ready_d;
            wave_q   <= wave_d;
            strobe_q <= strobe_d;
        end
    end

    volume_stepper #(
        .ResetValue (VOLUME_DEFAULT)
    ) u_volume_stepper (
        .clk_i   (system_clock),
        .rst_ni  (system_reset_n),
        .up_i    (volume_up),
        .down_i  (volume_down),
        .value_o (volume_control)
    );

    assign tone_ready  = ready_q;
    assign square_wave = wave_q;
    assign edge_strobe = strobe_q;

endmodule

// File: tb/tb_square_wave_generator.sv
// Self-checking bench for square_wave_generator: countdown/slot model checked
// every cycle, plus directed expectations at hand-computed points.
module tb_square_wave_generator;

    localparam int unsigned Def = 4;

    logic        system_clock = 1'b0;
    logic        system_reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [23:0] tone_half_period = '0;
    logic        tone_valid = 1'b0;
    logic        tone_ready;
    logic        volume_up = 1'b0;
    logic        volume_down = 1'b0;
    logic        square_wave;
    logic        edge_strobe;
    logic [3:0]  volume_control;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    square_wave_generator #(
        .DEFAULT_HALF_PERIOD (Def),
        .VOLUME_DEFAULT      (4'd8)
    ) dut (
        .system_clock     (system_clock),
        .system_reset_n   (system_reset_n),
        .enable           (enable),
        .tone_half_period (tone_half_period),
        .tone_valid       (tone_valid),
        .tone_ready       (tone_ready),
        .volume_up        (volume_up),
        .volume_down      (volume_down),
        .square_wave      (square_wave),
        .edge_strobe      (edge_strobe),
        .volume_control   (volume_control)
    );

    always #5 system_clock = ~system_clock;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: cycles left in the current half, a one-entry request slot.
    int unsigned m_active, m_left, m_pend;
    bit          m_have, m_sq, m_strobe, m_ready;
    int          m_vol;

    always @(posedge system_clock or negedge system_reset_n) begin : model
        int unsigned act, left, pend;
        bit          have, sq, stb, run, bnd;
        int          vol;
        if (!system_reset_n) begin
            m_active <= Def;
            m_left   <= Def;
            m_pend   <= 0;
            m_have   <= 0;
            m_sq     <= 0;
            m_strobe <= 0;
            m_ready  <= 1;
            m_vol    <= 8;
        end else begin
            act  = m_active;
            left = m_left;
            pend = m_pend;
            have = m_have;
            sq   = m_sq;
            vol  = m_vol;
            stb  = 0;
            run  = enable && (act != 0);
            bnd  = run && (left == 1);
            if (!run) begin
                if (sq) begin
                    sq  = 0;
                    stb = 1;
                end
            end else if (bnd) begin
                sq  = !sq;
                stb = 1;
            end else begin
                left = left - 1;
            end
            if (have && (bnd || !run)) begin
                act  = pend;
                have = 0;
            end
            if (bnd || !run) left = act;
            if (tone_valid && m_ready) begin
                pend = int'(tone_half_period);
                have = 1;
            end
            if (volume_up && !volume_down) vol = (vol >= 15) ? 15 : vol + 1;
            else if (volume_down && !volume_up) vol = (vol <= 0) ? 0 : vol - 1;
            m_active <= act;
            m_left   <= left;
            m_pend   <= pend;
            m_have   <= have;
            m_sq     <= sq;
            m_strobe <= stb;
            m_ready  <= !have;
            m_vol    <= vol;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge system_clock) begin
        if (system_reset_n && chk_on) begin
            chk("model_square_wave", int'(square_wave), int'(m_sq));
            chk("model_edge_strobe", int'(edge_strobe), int'(m_strobe));
            chk("model_tone_ready", int'(tone_ready), int'(m_ready));
            chk("model_volume", int'(volume_control), m_vol);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge system_clock);
        #1;
    endtask

    // Offer a request and hold tone_valid until it is taken.
    task automatic send(input int unsigned val);
        bit took;
        int n;
        tone_half_period = 24'(val);
        tone_valid = 1'b1;
        took = 0;
        n = 0;
        while (!took && n < 50) begin
            took = tone_ready;
            step(1);
            n++;
        end
        chk("send_accept", int'(took), 1);
    endtask

    task automatic pulse(input bit up, input bit down, input int n);
        repeat (n) begin
            volume_up = up;
            volume_down = down;
            step(1);
        end
        volume_up = 1'b0;
        volume_down = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n;
        #12;
        chk("rst_square_wave", int'(square_wave), 0);
        chk("rst_edge_strobe", int'(edge_strobe), 0);
        chk("rst_tone_ready", int'(tone_ready), 1);
        chk("rst_volume", int'(volume_control), 8);

        // 1: default half-period of 4
        @(posedge system_clock);
        #1;
        system_reset_n = 1'b1;
        enable = 1'b1;
        chk_on = 1;
        step(3);
        chk("t1_low_before_4th", int'(square_wave), 0);
        step(1);
        chk("t1_high_at_4th", int'(square_wave), 1);
        chk("t1_strobe_at_4th", int'(edge_strobe), 1);
        step(1);
        chk("t1_strobe_one_cycle", int'(edge_strobe), 0);

        // 2: half-period 2 sent at count 1
        tone_half_period = 24'd2;
        tone_valid = 1'b1;
        step(1);
        tone_valid = 1'b0;
        chk("t2_ready_low", int'(tone_ready), 0);
        step(1);
        chk("t2_ready_still_low", int'(tone_ready), 0);
        chk("t2_old_half_running", int'(square_wave), 1);
        step(1);
        chk("t2_toggle_at_4", int'(square_wave), 0);
        chk("t2_ready_back", int'(tone_ready), 1);
        step(1);
        chk("t2_half2_mid", int'(square_wave), 0);
        step(1);
        chk("t2_half2_toggle", int'(square_wave), 1);

        // 3: back-to-back 6 then 3
        send(6);
        send(3);
        tone_valid = 1'b0;
        step(5);
        chk("t3_six_half_end", int'(square_wave), 1);
        chk("t3_six_strobe", int'(edge_strobe), 1);
        step(3);
        chk("t3_three_half_end", int'(square_wave), 0);
        chk("t3_three_strobe", int'(edge_strobe), 1);

        // 4: silence, then restart with 3
        step(3);
        chk("t4_high_before_zero", int'(square_wave), 1);
        send(0);
        tone_valid = 1'b0;
        step(2);
        chk("t4_boundary_low", int'(square_wave), 0);
        chk("t4_boundary_strobe", int'(edge_strobe), 1);
        step(3);
        chk("t4_silent_low", int'(square_wave), 0);
        chk("t4_silent_no_strobe", int'(edge_strobe), 0);
        send(3);
        tone_valid = 1'b0;
        chk("t4_ready_low", int'(tone_ready), 0);
        step(1);
        chk("t4_commit_ready", int'(tone_ready), 1);
        step(2);
        chk("t4_not_yet", int'(square_wave), 0);
        step(1);
        chk("t4_first_toggle", int'(square_wave), 1);

        // enable low forces the wave low, rising enable restarts the half
        enable = 1'b0;
        step(1);
        chk("en_off_low", int'(square_wave), 0);
        chk("en_off_strobe", int'(edge_strobe), 1);
        step(1);
        enable = 1'b1;
        step(2);
        chk("en_on_wait", int'(square_wave), 0);
        step(1);
        chk("en_on_toggle", int'(square_wave), 1);

        // 5: volume
        pulse(1, 0, 10);
        chk("vol_sat_high", int'(volume_control), 15);
        pulse(0, 1, 3);
        chk("vol_down3", int'(volume_control), 12);
        pulse(1, 1, 1);
        chk("vol_both", int'(volume_control), 12);
        pulse(0, 1, 20);
        chk("vol_sat_low", int'(volume_control), 0);

        // 6: async reset with pending full and wave high
        n = 0;
        while (!(square_wave && edge_strobe) && n < 20) begin
            step(1);
            n++;
        end
        chk("t6_wave_high_found", int'(square_wave && edge_strobe), 1);
        send(5);
        tone_valid = 1'b0;
        chk("t6_pre_pending", int'(tone_ready), 0);
        chk("t6_pre_wave", int'(square_wave), 1);
        #2;
        system_reset_n = 1'b0;
        #1;
        chk("t6_rst_wave", int'(square_wave), 0);
        chk("t6_rst_strobe", int'(edge_strobe), 0);
        chk("t6_rst_ready", int'(tone_ready), 1);
        chk("t6_rst_volume", int'(volume_control), 8);
        @(posedge system_clock);
        #1;
        system_reset_n = 1'b1;
        step(3);
        chk("t6_restart_low", int'(square_wave), 0);
        step(1);
        chk("t6_restart_toggle", int'(square_wave), 1);
        step(3);
        chk("t6_default_mid", int'(square_wave), 1);
        step(1);
        chk("t6_pending_dropped", int'(square_wave), 0);
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
